gb_bus_write_sampler: RTL and testbench

//  Upstream front end for the MBC5 bank-register logic. Synchronises the asynchronous

---
 rtl/gb_bus_write_sampler.sv | 192 +++++++++++++++++++
 tb/tb_gb_bus_write_sampler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_bus_write_sampler.sv
// Purpose : cartridge-bus front end; synchronises A15-A12/D7-D0//CS//WR//RD and qualifies CPU writes.
// Latency : wrStrobe on the (SYNC_STAGES+1)th edge counting the edge that first samples /WR high.
// Backpr. : none; the pins cannot be stalled, so a write cut short by /RD or a runt is dropped.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   inputAddress/Data/CE/WR/RD asynchronous cartridge pins (/CS, /WR, /RD active low)
//   wrStrobe                  one-cycle pulse per committed write; wrAddr/wrData/wrCE valid with it
//   wrAddr, wrData, wrCE      values of the last committed write (held between strobes)
//   rdActive                  registered "synced /RD low and /WR high"
//   busError                  one-cycle pulse when /RD goes low during a write
//   runtCount                 saturating count of writes dropped for being too short
// Build option: define BUS_DEGLITCH_EN to require FILTER_CYCLES synced /WR-low cycles per
// write and to enable runtCount; without it every write commits and runtCount reads 0.
module gb_bus_write_sampler #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] inputAddress,
    input  logic [7:0] inputData,
    input  logic       inputCE,
    input  logic       inputWR,
    input  logic       inputRD,
    output logic       wrStrobe,
    output logic [3:0] wrAddr,
    output logic [7:0] wrData,
    output logic       wrCE,
    output logic       rdActive,
    output logic       busError,
    output logic [3:0] runtCount
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
        $error("FILTER_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_LOW = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    // Chain word: {vld, /CS, /RD, /WR, A[3:0], D[7:0]}. vld is a constant 1 fed in behind
    // reset so the last stage can tell real pin samples from reset fill values.
    localparam logic [15:0] SYNC_RST = 16'h7000;

    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] s_bus;
    logic        s_vld, s_ce, s_rd, s_wr;
    logic [3:0]  s_a;
    logic [7:0]  s_d;

    state_t      state_q, state_d;
    logic        capture, commit, abort;
    logic        armed_q;
    logic [3:0]  cap_a_q, wr_addr_q;
    logic [7:0]  cap_d_q, wr_data_q;
    logic        cap_ce_q, wr_ce_q;
    logic        rd_active_q, bus_err_q;

`ifdef BUS_DEGLITCH_EN
    localparam logic [3:0] FILTER_THR = 4'(FILTER_CYCLES);
    logic        runt;
    logic [3:0]  lowcnt_q, runt_cnt_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {1'b1, inputCE, inputRD, inputWR, inputAddress, inputData};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_bus = sync_q[SYNC_STAGES-1];
    assign s_vld = s_bus[15];
    assign s_ce  = s_bus[14];
    assign s_rd  = s_bus[13];
    assign s_wr  = s_bus[12];
    assign s_a   = s_bus[11:8];
    assign s_d   = s_bus[7:0];

    // armed_q blocks a /WR that was already low across reset from looking like a fresh
    // write: a real /WR-high sample must be seen before IDLE may start a write.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
`ifdef BUS_DEGLITCH_EN
        runt    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !s_wr && s_rd) begin
                    state_d = ST_WR_LOW;
                    capture = 1'b1;
                end
            end
            ST_WR_LOW: begin
                if (!s_rd) begin
                    state_d = ST_ABORT;
                    abort   = 1'b1;
                end else if (s_wr) begin
`ifdef BUS_DEGLITCH_EN
                    if (lowcnt_q >= FILTER_THR) begin
                        state_d = ST_COMMIT;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        runt    = 1'b1;
                    end
`else
                    state_d = ST_COMMIT;
                    commit  = 1'b1;
`endif
                end else begin
                    capture = 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_ABORT: begin
                if (s_wr && s_rd) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            cap_a_q     <= 4'd0;
            cap_d_q     <= 8'd0;
            cap_ce_q    <= 1'b1;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            wr_ce_q     <= 1'b1;
            rd_active_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_q | (s_vld & s_wr);
            if (capture) begin
                cap_a_q  <= s_a;
                cap_d_q  <= s_d;
                cap_ce_q <= s_ce;
            end
            if (commit) begin
                wr_addr_q <= cap_a_q;
                wr_data_q <= cap_d_q;
                wr_ce_q   <= cap_ce_q;
            end
            rd_active_q <= !s_rd && s_wr;
            bus_err_q   <= abort;
        end
    end

`ifdef BUS_DEGLITCH_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lowcnt_q   <= 4'd0;
            runt_cnt_q <= 4'd0;
        end else begin
            // First low cycle loads 1; later ones count up and stick at 15.
            if (capture) begin
                if (state_q == ST_IDLE)      lowcnt_q <= 4'd1;
                else if (lowcnt_q != 4'hF)   lowcnt_q <= lowcnt_q + 4'd1;
            end
            if (runt && runt_cnt_q != 4'hF) runt_cnt_q <= runt_cnt_q + 4'd1;
        end
    end
    assign runtCount = runt_cnt_q;
`else
    assign runtCount = 4'd0;
`endif

    assign wrStrobe = (state_q == ST_COMMIT);
    assign wrAddr   = wr_addr_q;
    assign wrData   = wr_data_q;
    assign wrCE     = wr_ce_q;
    assign rdActive = rd_active_q;
    assign busError = bus_err_q;

endmodule

// File: tb/tb_gb_bus_write_sampler.sv
// Purpose : randomized and directed check of gb_bus_write_sampler against a transaction model.
// Latency : expected strobes/errors are scheduled from the pin-level edge numbers of each transaction.
// Backpr. : none; the bench drives the pins freely.
module tb_gb_bus_write_sampler;

    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] inputAddress = 4'd0;
    logic [7:0] inputData = 8'd0;
    logic       inputCE = 1'b1;
    logic       inputWR = 1'b1;
    logic       inputRD = 1'b1;
    logic       wrStrobe, wrCE, rdActive, busError;
    logic [3:0] wrAddr, runtCount;
    logic [7:0] wrData;

    gb_bus_write_sampler #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .inputAddress(inputAddress),
        .inputData   (inputData),
        .inputCE     (inputCE),
        .inputWR     (inputWR),
        .inputRD     (inputRD),
        .wrStrobe    (wrStrobe),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .wrCE        (wrCE),
        .rdActive    (rdActive),
        .busError    (busError),
        .runtCount   (runtCount)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rst = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model state: committed writes and bus errors keyed by the edge after which they show.
    typedef struct {
        int         c;
        logic [3:0] a;
        logic [7:0] d;
        logic       ce;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_err[$];
    bit         rdact_hist [0:8191];
    logic [3:0] last_a = 4'd0;
    logic [7:0] last_d = 8'd0;
    logic       last_ce = 1'b1;
    int         runt_exp = 0;
    bit         mon_en = 1'b0;

    function automatic bit qualifies(input int nlow);
`ifdef BUS_DEGLITCH_EN
        return nlow >= FILTER_CYCLES;
`else
        return nlow >= 1;
`endif
    endfunction

    // Edge counter plus pin history; inputs only change #1 after an edge, so no race here.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            last_rst = cyc;
            exp_wr.delete();
            exp_err.delete();
            last_a  = 4'd0;
            last_d  = 8'd0;
            last_ce = 1'b1;
        end
        rdact_hist[cyc] = !inputRD && inputWR;
    end

    always @(negedge clock) begin
        bit e_wr;
        bit e_err;
        bit e_rd;
        if (mon_en) begin
            e_wr = (exp_wr.size() > 0) && (exp_wr[0].c == cyc);
            check("wrStrobe", {31'd0, wrStrobe}, {31'd0, e_wr});
            if (e_wr) begin
                last_a  = exp_wr[0].a;
                last_d  = exp_wr[0].d;
                last_ce = exp_wr[0].ce;
                void'(exp_wr.pop_front());
            end
            check("wrAddr", {28'd0, wrAddr}, {28'd0, last_a});
            check("wrData", {24'd0, wrData}, {24'd0, last_d});
            check("wrCE", {31'd0, wrCE}, {31'd0, last_ce});
            e_err = (exp_err.size() > 0) && (exp_err[0] == cyc);
            check("busError", {31'd0, busError}, {31'd0, e_err});
            if (e_err) void'(exp_err.pop_front());
            e_rd = (cyc - SYNC_STAGES > last_rst) ? rdact_hist[cyc - SYNC_STAGES] : 1'b0;
            check("rdActive", {31'd0, rdActive}, {31'd0, e_rd});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // /WR low for nlow sampled edges; d1 is on the bus during the last low cycle.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic ce, input int nlow, input int nhigh);
        int f;
        int r;
        wr_t w;
        inputAddress = a;
        inputData    = d0;
        inputCE      = ce;
        inputWR      = 1'b0;
        f = cyc + 1;
        tick(nlow - 1);
        inputData = d1;
        tick(1);
        inputWR = 1'b1;
        r = cyc + 1;
        if (qualifies(r - f)) begin
            w.c = r + SYNC_STAGES;
            w.a = a;
            w.d = d1;
            w.ce = ce;
            exp_wr.push_back(w);
        end else if (runt_exp < 15) begin
            runt_exp++;
        end
        inputAddress = 4'($urandom);
        inputData    = 8'($urandom);
        inputCE      = 1'($urandom);
        tick(nhigh);
    endtask

    task automatic do_read(input int nlow, input int nhigh);
        inputData = 8'($urandom);
        inputRD   = 1'b0;
        tick(nlow);
        inputRD = 1'b1;
        tick(nhigh);
    endtask

    // Write interrupted by /RD: error pulse, no strobe, recover only once both are high.
    task automatic do_abort(input int nbefore, input int nrd, input int nafter, input int nhigh);
        inputAddress = 4'($urandom);
        inputData    = 8'($urandom);
        inputWR      = 1'b0;
        tick(nbefore);
        inputRD = 1'b0;
        exp_err.push_back(cyc + 1 + SYNC_STAGES);
        tick(nrd);
        inputRD = 1'b1;
        tick(nafter);
        inputWR = 1'b1;
        tick(nhigh);
    endtask

    initial begin
        int op;
        // Reset held with /WR low; outputs must sit at reset values.
        tick(3);
        inputWR = 1'b0;
        tick(2);
        check("rst_wrStrobe", {31'd0, wrStrobe}, 32'd0);
        check("rst_wrAddr", {28'd0, wrAddr}, 32'd0);
        check("rst_wrData", {24'd0, wrData}, 32'd0);
        check("rst_wrCE", {31'd0, wrCE}, 32'd1);
        check("rst_rdActive", {31'd0, rdActive}, 32'd0);
        check("rst_busError", {31'd0, busError}, 32'd0);
        check("rst_runtCount", {28'd0, runtCount}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        // /WR still low from before reset: its rise must not produce a strobe.
        tick(5);
        inputWR = 1'b1;
        tick(6);

        do_write(4'h2, 8'h1F, 8'h1F, 1'b1, 6, 4);
        do_write(4'h4, 8'h05, 8'h0A, 1'b0, 5, 4);
        do_write(4'h7, 8'h33, 8'h33, 1'b0, 2, 4);
        tick(3);
        check("runtCount_short", {28'd0, runtCount}, runt_exp);
        do_abort(3, 2, 3, 4);
        do_write(4'h0, 8'h0A, 8'h0A, 1'b1, 5, 1);
        do_write(4'h0, 8'h00, 8'h00, 1'b1, 5, 4);
        do_read(4, 3);
        tick(3);

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 5));
            if (op <= 2)
                do_write(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                         int'($urandom_range(1, 8)), int'($urandom_range(2, 5)));
            else if (op == 3)
                do_read(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
            else
                do_abort(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(2, 4)));
            tick(3);
            check("runtCount", {28'd0, runtCount}, runt_exp);
        end

        tick(8);
        check("pending_strobes", exp_wr.size(), 32'd0);
        check("pending_errors", exp_err.size(), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
